dsp_mac_pipelined: RTL and testbench
====================================

# dsp_mac_pipelined

Parametrised, pipelined multiply / multiply-accumulate unit, the generalisation of our combinational DSP multiply tests. It is written so the Cyclone 10 LP DSP template can map it onto `cyclone10lp_mac_mult` plus fabric or output registers. It adds four things the plain multiply lacks:
- configurable operand width and signedness;
- 0–3 product pipeline stages;
- valid tracking with clock-enable stall;
- a wrapping accumulator.

## Interface
- `WIDTH`, 18: operand width, 2..18.
- `SIGNED`, 0: 0 = unsigned operands, 1 = two's-complement operands.
- `STAGES`, 2: product pipeline registers before the accumulator register, 0..3.
- `ACC_WIDTH`, 48: accumulator/result width, ≥ 2·`WIDTH`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ce`  in  1  clock enable. When 0, every register holds.
- `in_valid`  in  1  a/b/acc sample is valid this cycle.
- `a`  in  `WIDTH`  operand A.
- `b`  in  `WIDTH`  operand B.
- `acc`  in  1  1 = add the product to the accumulator; 0 = load the product into it.
- `p`  out  `ACC_WIDTH`  accumulator register value.
- `out_valid`  out  1  `p` was updated by a valid sample on the last enabled edge.

## Operation
- **Product**
  - prod = a × b, full 2·`WIDTH` bits, signed or unsigned per `SIGNED`.
  - Extend prod to `ACC_WIDTH`: sign-extend if `SIGNED`=1, otherwise zero-extend.
- **Product pipeline**
  - `STAGES` registers carry {prod-or-operands, valid, acc} in lockstep.
  - The internal split between operand and product registers is free.
  - The observable latency is fixed (see Timing).
- **Accumulator register** (always present), on an edge with `ce`=1:
  - last-stage valid=1, acc=0: p ← ext(prod).
  - last-stage valid=1, acc=1: p ← p + ext(prod), modulo 2^`ACC_WIDTH` (wraps silently, no saturation, no flag).
  - last-stage valid=0 (bubble): p holds. Bubbles never alter or clear the accumulator.
  - `out_valid` ← last-stage valid.
- **Stall:** on an edge with `ce`=0, all pipeline registers, valids, `p` and `out_valid` hold. No sample is dropped or duplicated.
- **Ignored inputs:** `a`, `b` and `acc` are ignored when `in_valid`=0 or `ce`=0.
- **Stage-0 mode** (`STAGES`=0): prod feeds the accumulator adder combinationally.
- **Reset:** `rst_n` low asynchronously clears every register, including mid-stream. In-flight samples are discarded; the first valid sample after reset must use acc=0 for a defined result.

## Timing
- Reset values: `p`=0, `out_valid`=0, all internal valids 0.
- Latency:
  - A sample accepted on enabled edge N updates `p` and asserts `out_valid` on enabled edge N+`STAGES`+1.
  - Disabled edges do not count toward latency.
- Throughput: one sample per enabled cycle.
- Back-to-back accumulate: a sample with acc=1 sees the `p` produced by the immediately preceding valid sample, even when that sample was one cycle ahead. The adder feeds back from its own register, with no hazard bubble.
- `out_valid` is high for exactly one enabled cycle per valid sample. It stays high across stalls because it holds with the rest of the pipeline.
- Simultaneous `rst_n` deassertion and `in_valid`=1: the sample is accepted on the first rising edge after deassertion.

## Test plan
- **Reset** (`WIDTH`=18, `STAGES`=2): hold `rst_n`=0 with random inputs. Require `p`=0 and `out_valid`=0; after release, `out_valid` stays 0 until 3 enabled edges after the first valid sample.
- **Unsigned max**: a=b=0x3FFFF, acc=0, one valid cycle. Require `p`=0x0000FFFF80001 and `out_valid`=1 for exactly one cycle, 3 edges later.
- **Back-to-back accumulate**:
  - Stimulus: (3,4,acc0), (5,6,acc1), (7,8,acc1) on consecutive cycles, then a bubble, then (2,2,acc1).
  - Require `p` = 12, 42, 98 on consecutive cycles, then hold 98 with `out_valid`=0, then 102.
- **Signed** (`SIGNED`=1): a=0x3FFFF (−1), b=2, acc=0. Require `p`=0xFFFFFFFFFFFE.
- **Stall**:
  - Stimulus: stream the accumulate sequence with `ce`=0 for 2 cycles between samples 1 and 2.
  - Require: outputs frozen during the stall, the same results 12, 42, 98 delayed by 2 cycles, no duplicate `out_valid`.
  - Repeat with `STAGES`=0 and `STAGES`=3.
- **Wrap and mid-stream reset**:
  - Wrap: `ACC_WIDTH`=36, a=b=0x3FFFF with acc0 then acc1. Require `p`=0xFFFF80001, then 0xFFFF00002.
  - Mid-stream reset: pulse `rst_n` low while samples are in flight. Require `p`=0 and `out_valid`=0 immediately, and no stale results afterwards.

Source files
------------

// File: rtl/dsp_mac_pipelined_if.sv
// Sample/result bundle for dsp_mac_pipelined: operand side driven by the master,
// accumulator result returned by the slave (the MAC itself).
interface dsp_mac_pipelined_if #(
    parameter int WIDTH     = 18,
    parameter int ACC_WIDTH = 48
);
    logic                 ce;
    logic                 in_valid;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 acc;
    logic [ACC_WIDTH-1:0] p;
    logic                 out_valid;

    modport master (
        output ce, in_valid, a, b, acc,
        input  p, out_valid
    );

    modport slave (
        input  ce, in_valid, a, b, acc,
        output p, out_valid
    );
endinterface

// File: rtl/dsp_mac_pipelined.sv
// Pipelined multiply / multiply-accumulate: operand register, STAGES product
// registers, then a wrapping accumulator register. ce stalls every register.
module dsp_mac_pipelined #(
    parameter int WIDTH     = 18,
    parameter int SIGNED    = 0,
    parameter int STAGES    = 2,
    parameter int ACC_WIDTH = 48
) (
    input logic           clk,
    input logic           rst_n,
    dsp_mac_pipelined_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 vld_q;
    logic                 acc_q;
    logic [PW-1:0]        prod_c;
    logic [PW-1:0]        last_prod;
    logic                 last_vld;
    logic                 last_acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] p_q;
    logic                 ov_q;

    // Operand register: the sample is taken here on the accepting edge; operands
    // only load on valid samples so idle inputs do not toggle the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= 1'b0;
            acc_q <= 1'b0;
        end else if (bus.ce) begin
            vld_q <= bus.in_valid;
            acc_q <= bus.in_valid & bus.acc;
            if (bus.in_valid) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
        end
    end

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [PW-1:0] a_x;
            logic signed [PW-1:0] b_x;
            assign a_x      = PW'($signed(a_q));
            assign b_x      = PW'($signed(b_q));
            assign prod_c   = a_x * b_x;
            assign prod_ext = ACC_WIDTH'($signed(last_prod));
        end else begin : g_unsigned
            logic [PW-1:0] a_x;
            logic [PW-1:0] b_x;
            assign a_x      = PW'(a_q);
            assign b_x      = PW'(b_q);
            assign prod_c   = a_x * b_x;
            assign prod_ext = ACC_WIDTH'(last_prod);
        end
    endgenerate

    generate
        if (STAGES == 0) begin : g_comb
            assign last_prod = prod_c;
            assign last_vld  = vld_q;
            assign last_acc  = acc_q;
        end else begin : g_pipe
            logic [PW-1:0]     prod_q [STAGES];
            logic [STAGES-1:0] vld_p;
            logic [STAGES-1:0] acc_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        prod_q[i] <= '0;
                    end
                    vld_p <= '0;
                    acc_p <= '0;
                end else if (bus.ce) begin
                    prod_q[0] <= prod_c;
                    vld_p[0]  <= vld_q;
                    acc_p[0]  <= acc_q;
                    for (int i = 1; i < STAGES; i++) begin
                        prod_q[i] <= prod_q[i-1];
                        vld_p[i]  <= vld_p[i-1];
                        acc_p[i]  <= acc_p[i-1];
                    end
                end
            end

            assign last_prod = prod_q[STAGES-1];
            assign last_vld  = vld_p[STAGES-1];
            assign last_acc  = acc_p[STAGES-1];
        end
    endgenerate

    // Feedback comes straight from p_q, so back-to-back accumulates need no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            ov_q <= 1'b0;
        end else if (bus.ce) begin
            ov_q <= last_vld;
            if (last_vld) begin
                p_q <= last_acc ? (p_q + prod_ext) : prod_ext;
            end
        end
    end

    assign bus.p         = p_q;
    assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_dsp_mac_pipelined.sv
// Directed bench for dsp_mac_pipelined across five parameter sets with
// hand-computed expected accumulator values and out_valid timing.
module tb_dsp_mac_pipelined;
    logic        clk;
    logic        rst_n;
    logic [4:0]  ce_d;
    logic [4:0]  iv_d;
    logic [17:0] a_d;
    logic [17:0] b_d;
    logic        acc_d;
    logic [47:0] p_o  [5];
    logic        ov_o [5];
    int          checks;
    int          errors;

    dsp_mac_pipelined_if #(.WIDTH(18), .ACC_WIDTH(48)) if0 ();
    dsp_mac_pipelined_if #(.WIDTH(18), .ACC_WIDTH(48)) if1 ();
    dsp_mac_pipelined_if #(.WIDTH(18), .ACC_WIDTH(48)) if2 ();
    dsp_mac_pipelined_if #(.WIDTH(18), .ACC_WIDTH(48)) if3 ();
    dsp_mac_pipelined_if #(.WIDTH(18), .ACC_WIDTH(36)) if4 ();

    dsp_mac_pipelined #(.WIDTH(18), .SIGNED(0), .STAGES(2), .ACC_WIDTH(48))
        u_uns2 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dsp_mac_pipelined #(.WIDTH(18), .SIGNED(1), .STAGES(2), .ACC_WIDTH(48))
        u_sgn2 (.clk(clk), .rst_n(rst_n), .bus(if1));
    dsp_mac_pipelined #(.WIDTH(18), .SIGNED(0), .STAGES(0), .ACC_WIDTH(48))
        u_uns0 (.clk(clk), .rst_n(rst_n), .bus(if2));
    dsp_mac_pipelined #(.WIDTH(18), .SIGNED(0), .STAGES(3), .ACC_WIDTH(48))
        u_uns3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    dsp_mac_pipelined #(.WIDTH(18), .SIGNED(0), .STAGES(2), .ACC_WIDTH(36))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(if4));

    assign if0.ce = ce_d[0]; assign if0.in_valid = iv_d[0];
    assign if1.ce = ce_d[1]; assign if1.in_valid = iv_d[1];
    assign if2.ce = ce_d[2]; assign if2.in_valid = iv_d[2];
    assign if3.ce = ce_d[3]; assign if3.in_valid = iv_d[3];
    assign if4.ce = ce_d[4]; assign if4.in_valid = iv_d[4];
    assign if0.a = a_d; assign if0.b = b_d; assign if0.acc = acc_d;
    assign if1.a = a_d; assign if1.b = b_d; assign if1.acc = acc_d;
    assign if2.a = a_d; assign if2.b = b_d; assign if2.acc = acc_d;
    assign if3.a = a_d; assign if3.b = b_d; assign if3.acc = acc_d;
    assign if4.a = a_d; assign if4.b = b_d; assign if4.acc = acc_d;

    assign p_o[0] = if0.p; assign ov_o[0] = if0.out_valid;
    assign p_o[1] = if1.p; assign ov_o[1] = if1.out_valid;
    assign p_o[2] = if2.p; assign ov_o[2] = if2.out_valid;
    assign p_o[3] = if3.p; assign ov_o[3] = if3.out_valid;
    assign p_o[4] = {12'b0, if4.p}; assign ov_o[4] = if4.out_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic c, input logic v,
                         input logic [17:0] aa, input logic [17:0] bb, input logic ac);
        for (int i = 0; i < 5; i++) begin
            ce_d[i] = 1'b1;
            iv_d[i] = 1'b0;
        end
        ce_d[k] = c;
        iv_d[k] = v;
        a_d     = aa;
        b_d     = bb;
        acc_d   = ac;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b1, 1'b0, 18'($urandom), 18'($urandom), 1'($urandom));
    endtask

    task automatic check(input string tag, input int k, input logic [47:0] ep, input logic eo);
        checks++;
        assert ({ov_o[k], p_o[k]} === {eo, ep}) else begin
            errors++;
            $error("FAIL %s inst%0d got p=%h ov=%b exp p=%h ov=%b",
                   tag, k, p_o[k], ov_o[k], ep, eo);
        end
    endtask

    // Sample 1, two disabled edges, samples 2 and 3; results land STAGES+1
    // enabled edges after acceptance, i.e. tick s+3, s+4, s+5.
    task automatic stall_run(input int k, input int s, input logic [47:0] p_prev);
        logic [47:0] ep;
        logic        eo;
        for (int t = 0; t < s + 8; t++) begin
            case (t)
                0:       drive(k, 1'b1, 1'b1, 18'd3, 18'd4, 1'b0);
                1, 2:    drive(k, 1'b0, 1'b1, 18'd9, 18'd9, 1'b1);
                3:       drive(k, 1'b1, 1'b1, 18'd5, 18'd6, 1'b1);
                4:       drive(k, 1'b1, 1'b1, 18'd7, 18'd8, 1'b1);
                default: idle(k);
            endcase
            tick();
            if (t < s + 3) begin
                ep = p_prev; eo = 1'b0;
            end else if (t == s + 3) begin
                ep = 48'd12; eo = 1'b1;
            end else if (t == s + 4) begin
                ep = 48'd42; eo = 1'b1;
            end else if (t == s + 5) begin
                ep = 48'd98; eo = 1'b1;
            end else begin
                ep = 48'd98; eo = 1'b0;
            end
            check($sformatf("stall_s%0d_t%0d", s, t), k, ep, eo);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ce_d   = '1;
        iv_d   = '1;
        a_d    = 18'($urandom);
        b_d    = 18'($urandom);
        acc_d  = 1'b1;

        // Reset held with random valid traffic
        for (int t = 0; t < 3; t++) begin
            a_d   = 18'($urandom);
            b_d   = 18'($urandom);
            acc_d = 1'($urandom);
            tick();
            for (int k = 0; k < 5; k++) check("reset_hold", k, 48'd0, 1'b0);
        end

        // Release coincident with a valid sample
        drive(0, 1'b1, 1'b1, 18'd2, 18'd3, 1'b0);
        rst_n = 1'b1;
        tick();
        check("rel_e0", 0, 48'd0, 1'b0);
        idle(0);
        tick();
        check("rel_e1", 0, 48'd0, 1'b0);
        tick();
        check("rel_e2", 0, 48'd0, 1'b0);
        tick();
        check("rel_e3", 0, 48'd6, 1'b1);

        // Unsigned max operands
        drive(0, 1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 1'b0);
        tick();
        check("umax_e0", 0, 48'd6, 1'b0);
        idle(0);
        tick();
        tick();
        check("umax_e2", 0, 48'd6, 1'b0);
        tick();
        check("umax_e3", 0, 48'h0000FFFF80001, 1'b1);
        tick();
        check("umax_e4", 0, 48'h0000FFFF80001, 1'b0);

        // Back-to-back accumulate with a bubble
        drive(0, 1'b1, 1'b1, 18'd3, 18'd4, 1'b0);
        tick();
        drive(0, 1'b1, 1'b1, 18'd5, 18'd6, 1'b1);
        tick();
        drive(0, 1'b1, 1'b1, 18'd7, 18'd8, 1'b1);
        tick();
        check("b2b_pre", 0, 48'h0000FFFF80001, 1'b0);
        idle(0);
        tick();
        check("b2b_12", 0, 48'd12, 1'b1);
        drive(0, 1'b1, 1'b1, 18'd2, 18'd2, 1'b1);
        tick();
        check("b2b_42", 0, 48'd42, 1'b1);
        idle(0);
        tick();
        check("b2b_98", 0, 48'd98, 1'b1);
        tick();
        check("b2b_bubble", 0, 48'd98, 1'b0);
        tick();
        check("b2b_102", 0, 48'd102, 1'b1);
        tick();
        check("b2b_done", 0, 48'd102, 1'b0);

        // Signed operands
        drive(1, 1'b1, 1'b1, 18'h3FFFF, 18'd2, 1'b0);
        tick();
        drive(1, 1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 1'b1);
        tick();
        drive(1, 1'b1, 1'b1, 18'h20000, 18'h20000, 1'b0);
        tick();
        check("sgn_pre", 1, 48'd0, 1'b0);
        idle(1);
        tick();
        check("sgn_m2", 1, 48'hFFFFFFFFFFFE, 1'b1);
        tick();
        check("sgn_m1", 1, 48'hFFFFFFFFFFFF, 1'b1);
        tick();
        check("sgn_min2", 1, 48'h000400000000, 1'b1);
        tick();
        check("sgn_done", 1, 48'h000400000000, 1'b0);

        // 36-bit accumulator wrap
        drive(4, 1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 1'b0);
        tick();
        drive(4, 1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 1'b1);
        tick();
        idle(4);
        tick();
        check("wrap_pre", 4, 48'd0, 1'b0);
        tick();
        check("wrap_load", 4, 48'h0000FFFF80001, 1'b1);
        tick();
        check("wrap_add", 4, 48'h0000FFFF00002, 1'b1);
        tick();
        check("wrap_done", 4, 48'h0000FFFF00002, 1'b0);

        // Stalls across three pipeline depths
        stall_run(0, 2, 48'd102);
        stall_run(2, 0, 48'd0);
        stall_run(3, 3, 48'd0);

        // out_valid held high through a stall, then exactly one more enabled cycle
        drive(0, 1'b1, 1'b1, 18'd1, 18'd1, 1'b0);
        tick();
        idle(0);
        tick();
        tick();
        check("hold_pre", 0, 48'd98, 1'b0);
        tick();
        check("hold_out", 0, 48'd1, 1'b1);
        drive(0, 1'b0, 1'b1, 18'd9, 18'd9, 1'b0);
        tick();
        check("hold_st1", 0, 48'd1, 1'b1);
        tick();
        check("hold_st2", 0, 48'd1, 1'b1);
        idle(0);
        tick();
        check("hold_end", 0, 48'd1, 1'b0);

        // Mid-stream reset with samples in flight
        drive(0, 1'b1, 1'b1, 18'd3, 18'd4, 1'b0);
        tick();
        drive(0, 1'b1, 1'b1, 18'd5, 18'd6, 1'b1);
        tick();
        idle(0);
        rst_n = 1'b0;
        #1;
        check("mrst_async", 0, 48'd0, 1'b0);
        tick();
        check("mrst_held", 0, 48'd0, 1'b0);
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("mrst_post%0d", t), 0, 48'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
